// File: rtl/lorenz_step_engine.sv
// Forward-Euler Lorenz integrator driven by the HPS step/parameter PIOs.
// Four products share one signed 32x32 multiplier, one per cycle, then a single update cycle.
module lorenz_step_engine #(
  parameter int FRAC     = 20,
  parameter int DT_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_clk_i,
  input  logic        step_reset_i,
  input  logic [31:0] x_init_i,
  input  logic [31:0] y_init_i,
  input  logic [31:0] z_init_i,
  input  logic [31:0] sigma_i,
  input  logic [31:0] beta_i,
  input  logic [31:0] rho_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic [31:0] z_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [31:0] step_count_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] M0   = 3'd1;
  localparam logic [2:0] M1   = 3'd2;
  localparam logic [2:0] M2   = 3'd3;
  localparam logic [2:0] M3   = 3'd4;
  localparam logic [2:0] UPD  = 3'd5;

  logic [2:0]         state_reg;
  logic               s_q;
  logic               rise;
  logic signed [31:0] sigma_reg, beta_reg, rho_reg;
  logic signed [31:0] wx_reg, wy_reg, wz_reg;
  logic signed [31:0] p0_reg, p1_reg, p2_reg, p3_reg;
  logic signed [31:0] x_reg, y_reg, z_reg;
  logic [31:0]        count_reg;
  logic               overrun_reg;

  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] mul_full;
  logic signed [31:0] prod;
  logic               unused_mul_bits;
  logic signed [31:0] diff_yx, diff_rz, dy_num, dz_num;

  assign rise = step_clk_i & ~s_q;

  assign diff_yx = wy_reg - wx_reg;
  assign diff_rz = rho_reg - wz_reg;
  assign dy_num  = p1_reg - y_reg;
  assign dz_num  = p2_reg - p3_reg;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      M0: begin mul_a = sigma_reg; mul_b = diff_yx; end
      M1: begin mul_a = wx_reg;    mul_b = diff_rz; end
      M2: begin mul_a = wx_reg;    mul_b = wy_reg;  end
      M3: begin mul_a = beta_reg;  mul_b = wz_reg;  end
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  // Middle slice of the full product is floor(a*b/2^FRAC), wrapped to 32 bits.
  assign mul_full        = mul_a * mul_b;
  assign prod            = mul_full[FRAC+31:FRAC];
  assign unused_mul_bits = ^{mul_full[63:FRAC+32], mul_full[FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      s_q         <= 1'b0;
      sigma_reg   <= '0;
      beta_reg    <= '0;
      rho_reg     <= '0;
      wx_reg      <= '0;
      wy_reg      <= '0;
      wz_reg      <= '0;
      p0_reg      <= '0;
      p1_reg      <= '0;
      p2_reg      <= '0;
      p3_reg      <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      s_q <= step_clk_i;
      if (step_reset_i) begin
        // Load wins over everything, including a step already in flight.
        x_reg       <= x_init_i;
        y_reg       <= y_init_i;
        z_reg       <= z_init_i;
        count_reg   <= '0;
        overrun_reg <= 1'b0;
        state_reg   <= IDLE;
      end else begin
        if (rise && state_reg != IDLE)
          overrun_reg <= 1'b1;
        case (state_reg)
          IDLE: if (rise) begin
            sigma_reg <= sigma_i;
            beta_reg  <= beta_i;
            rho_reg   <= rho_i;
            wx_reg    <= x_reg;
            wy_reg    <= y_reg;
            wz_reg    <= z_reg;
            state_reg <= M0;
          end
          M0: begin p0_reg <= prod; state_reg <= M1; end
          M1: begin p1_reg <= prod; state_reg <= M2; end
          M2: begin p2_reg <= prod; state_reg <= M3; end
          M3: begin p3_reg <= prod; state_reg <= UPD; end
          UPD: begin
            x_reg     <= x_reg + (p0_reg >>> DT_SHIFT);
            y_reg     <= y_reg + (dy_num >>> DT_SHIFT);
            z_reg     <= z_reg + (dz_num >>> DT_SHIFT);
            count_reg <= count_reg + 32'd1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Busy also covers the cycle in which an accepted strobe edge is pending.
  assign busy_o       = reset_n & ((state_reg != IDLE) | (rise & ~step_reset_i));
  assign x_o          = x_reg;
  assign y_o          = y_reg;
  assign z_o          = z_reg;
  assign overrun_o    = overrun_reg;
  assign step_count_o = count_reg;

endmodule

// File: tb/tb_lorenz_step_engine.sv
// Self-checking bench for lorenz_step_engine against a plain-arithmetic Euler model.
module tb_lorenz_step_engine;
  localparam int FRAC     = 20;
  localparam int DT_SHIFT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_clk_i = 1'b0;
  logic        step_reset_i = 1'b0;
  logic [31:0] x_init_i = '0, y_init_i = '0, z_init_i = '0;
  logic [31:0] sigma_i = '0, beta_i = '0, rho_i = '0;
  logic [31:0] x_o, y_o, z_o, step_count_o;
  logic        busy_o, overrun_o;

  int errors = 0;
  int checks = 0;
  int mx, my, mz, msig, mbeta, mrho, mcount;

  always #5 clk = ~clk;

  lorenz_step_engine #(.FRAC(FRAC), .DT_SHIFT(DT_SHIFT)) dut (
    .clk(clk), .reset_n(reset_n), .step_clk_i(step_clk_i), .step_reset_i(step_reset_i),
    .x_init_i(x_init_i), .y_init_i(y_init_i), .z_init_i(z_init_i),
    .sigma_i(sigma_i), .beta_i(beta_i), .rho_i(rho_i),
    .x_o(x_o), .y_o(y_o), .z_o(z_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .step_count_o(step_count_o)
  );

  function automatic int fmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> FRAC);
  endfunction

  function automatic void model_step();
    int p0, p1, p2, p3;
    p0 = fmul(msig, my - mx);
    p1 = fmul(mx, mrho - mz);
    p2 = fmul(mx, my);
    p3 = fmul(mbeta, mz);
    mx = mx + (p0 >>> DT_SHIFT);
    my = my + ((p1 - my) >>> DT_SHIFT);
    mz = mz + ((p2 - p3) >>> DT_SHIFT);
    mcount = mcount + 1;
  endfunction

  task automatic set_params(input int s, input int b, input int r);
    msig = s; mbeta = b; mrho = r;
    sigma_i = s; beta_i = b; rho_i = r;
  endtask

  task automatic load_state(input int x, input int y, input int z);
    x_init_i = x; y_init_i = y; z_init_i = z;
    step_reset_i = 1'b1;
    @(negedge clk);
    step_reset_i = 1'b0;
    mx = x; my = y; mz = z; mcount = 0;
  endtask

  // Raise the strobe, drop it next cycle, count busy samples until busy falls.
  task automatic pulse_step(output int busy_cycles, output bit timed_out);
    int n;
    bit done;
    n = 0; done = 1'b0;
    step_clk_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (busy_o) n++;
      else if (i > 0) done = 1'b1;
      if (!done) begin
        @(negedge clk);
        step_clk_i = 1'b0;
      end
    end
    busy_cycles = n;
    timed_out = !done;
  endtask

  task automatic test_reset();
    bit changed;
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk_i = 1'($urandom); step_reset_i = 1'($urandom);
      x_init_i = $urandom; y_init_i = $urandom; z_init_i = $urandom;
      sigma_i = $urandom; beta_i = $urandom; rho_i = $urandom;
      @(negedge clk); #1;
      checks++;
      if ({x_o, y_o, z_o, step_count_o, busy_o, overrun_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got x=%h y=%h z=%h cnt=%h busy=%b ovr=%b expected all 0",
                 x_o, y_o, z_o, step_count_o, busy_o, overrun_o);
      end
    end
    @(negedge clk);
    reset_n = 1'b1; step_clk_i = 1'b0; step_reset_i = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if ({x_o, y_o, z_o, step_count_o, busy_o, overrun_o} !== '0) changed = 1'b1;
    end
    checks++;
    if (changed) begin
      errors++;
      $display("FAIL idle_hold: outputs moved with no strobe, now x=%h cnt=%h expected 0", x_o, step_count_o);
    end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_step();
    int n;
    bit to;
    set_params(32'h00A00000, 32'h002AAAAA, 32'h01C00000);
    load_state(32'hFFF00000, 32'h00019999, 32'h01900000);
    pulse_step(n, to);
    checks++;
    if (to || n != 6) begin
      errors++;
      $display("FAIL busy_cycles: got %0d (timeout=%b) expected 6", n, to);
    end
    checks++;
    if (x_o !== 32'hFFF0AFFF) begin errors++; $display("FAIL single_x: got %h expected fff0afff", x_o); end
    checks++;
    if (y_o !== 32'h000167FF) begin errors++; $display("FAIL single_y: got %h expected 000167ff", y_o); end
    checks++;
    if (z_o !== 32'h018BD3BB) begin errors++; $display("FAIL single_z: got %h expected 018bd3bb", z_o); end
    checks++;
    if (step_count_o !== 32'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", step_count_o); end
    $display("test_single_step x=%h y=%h z=%h busy_cycles=%0d", x_o, y_o, z_o, n);
  endtask

  task automatic test_held_strobe();
    set_params(32'h00A00000, 32'h002AAAAA, 32'h01C00000);
    load_state(32'h00100000, 32'h00200000, 32'h00300000);
    step_clk_i = 1'b1;
    repeat (50) @(negedge clk);
    step_clk_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    model_step();
    checks++;
    if (step_count_o !== 32'd1) begin errors++; $display("FAIL held_count: got %0d expected 1", step_count_o); end
    checks++;
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL held_overrun: got %b expected 0", overrun_o); end
    checks++;
    if (x_o !== mx || y_o !== my || z_o !== mz) begin
      errors++;
      $display("FAIL held_state: got %h %h %h expected %h %h %h", x_o, y_o, z_o, mx, my, mz);
    end
    @(negedge clk);
    $display("test_held_strobe count=%0d", step_count_o);
  endtask

  task automatic test_overrun();
    set_params(32'h00A00000, 32'h002AAAAA, 32'h01C00000);
    load_state(32'hFFF00000, 32'h00019999, 32'h01900000);
    step_clk_i = 1'b1; @(negedge clk);
    step_clk_i = 1'b0; @(negedge clk);
    step_clk_i = 1'b1; @(negedge clk);
    step_clk_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    model_step();
    checks++;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun_o); end
    checks++;
    if (step_count_o !== 32'd1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", step_count_o); end
    checks++;
    if (x_o !== mx || y_o !== my || z_o !== mz) begin
      errors++;
      $display("FAIL overrun_state: got %h %h %h expected %h %h %h", x_o, y_o, z_o, mx, my, mz);
    end
    @(negedge clk);
    step_reset_i = 1'b1; @(negedge clk);
    step_reset_i = 1'b0; @(negedge clk);
    #1;
    checks++;
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun_o); end
    @(negedge clk);
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid_step();
    int n, bx, by, bz;
    bit to;
    set_params($urandom, $urandom, $urandom);
    load_state($urandom, $urandom, $urandom);
    pulse_step(n, to);
    checks++;
    if (step_count_o !== 32'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", step_count_o); end
    bx = $urandom; by = $urandom; bz = $urandom;
    step_clk_i = 1'b1; @(negedge clk);
    step_clk_i = 1'b0; @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy_o); end
    x_init_i = bx; y_init_i = by; z_init_i = bz;
    step_reset_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (x_o !== bx || y_o !== by || z_o !== bz) begin
      errors++;
      $display("FAIL mid_load: got %h %h %h expected %h %h %h", x_o, y_o, z_o, bx, by, bz);
    end
    checks++;
    if (busy_o !== 1'b0 || step_count_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_idle: got busy=%b cnt=%0d expected busy=0 cnt=0", busy_o, step_count_o);
    end
    // Strobe activity during load must be ignored, and a strobe high at release must not fire.
    step_clk_i = 1'b1; @(negedge clk);
    step_clk_i = 1'b0; @(negedge clk);
    step_clk_i = 1'b1; @(negedge clk);
    step_reset_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (step_count_o !== 32'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_upd: got cnt=%0d busy=%b expected cnt=0 busy=0", step_count_o, busy_o);
    end
    checks++;
    if (x_o !== bx || y_o !== by || z_o !== bz) begin
      errors++;
      $display("FAIL mid_hold: got %h %h %h expected %h %h %h", x_o, y_o, z_o, bx, by, bz);
    end
    @(negedge clk);
    step_clk_i = 1'b0;
    @(negedge clk);
    $display("test_reset_mid_step done");
  endtask

  task automatic test_wrap();
    int n;
    bit to;
    set_params(32'h00A00000, $urandom, $urandom);
    load_state(32'h7FF00000, 32'h7FF00000, $urandom);
    pulse_step(n, to);
    checks++;
    if (x_o !== 32'h7FF00000) begin errors++; $display("FAIL wrap_x_same: got %h expected 7ff00000", x_o); end
    load_state(32'h7FF00000, 32'h80000000, $urandom);
    for (int i = 0; i < 1000; i++) begin
      set_params($urandom, $urandom, $urandom);
      pulse_step(n, to);
      model_step();
      checks++;
      if (to || x_o !== mx || y_o !== my || z_o !== mz || step_count_o !== mcount) begin
        errors++;
        $display("FAIL wrap_step%0d: got %h %h %h cnt=%0d expected %h %h %h cnt=%0d",
                 i, x_o, y_o, z_o, step_count_o, mx, my, mz, mcount);
      end
    end
    $display("test_wrap final x=%h y=%h z=%h cnt=%0d", x_o, y_o, z_o, step_count_o);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_step();
    test_held_strobe();
    test_overrun();
    test_reset_mid_step();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
